// File: rtl/fifo_axis_packer_if.sv
// AXI-Stream-style beat interface carrying packed output beats.
//   tvalid : beat valid (master -> slave)
//   tready : slave can accept (slave -> master)
//   tdata  : packed beat, DATA_WIDTH*PACK_RATIO bits, word 0 in the low slice
//   tkeep  : per-word valid mask, one bit per packed word
//   tlast  : beat was terminated by a flush
interface fifo_axis_packer_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PACK_RATIO = 4
);
  localparam int unsigned OUT_WIDTH = DATA_WIDTH * PACK_RATIO;

  logic                  tvalid;
  logic                  tready;
  logic [OUT_WIDTH-1:0]  tdata;
  logic [PACK_RATIO-1:0] tkeep;
  logic                  tlast;

  modport master (
    output tvalid,
    output tdata,
    output tkeep,
    output tlast,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tkeep,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/fifo_axis_packer.sv
// Pops words from a show-ahead FIFO and packs PACK_RATIO consecutive words into one
// wide beat, presented on a registered valid/ready master port. A flush pulse forces
// out a partial beat (tkeep marks the filled words, tlast=1).
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   fifo_empty        : FIFO empty flag
//   fifo_rd_data      : FIFO head word (valid while fifo_empty=0)
//   fifo_rd_en        : pop strobe to FIFO (combinational)
//   flush             : single-cycle request to emit the partial accumulator
//   flush_done        : one-cycle pulse when a flush completes
//   m                 : packed beat output (master modport)
//   acc_level         : words currently held in the accumulator
module fifo_axis_packer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PACK_RATIO = 4,
  parameter int unsigned OUT_WIDTH  = DATA_WIDTH * PACK_RATIO,
  parameter int unsigned LVL_WIDTH  = $clog2(PACK_RATIO + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  input  logic                  flush,
  output logic                  flush_done,
  fifo_axis_packer_if.master    m,
  output logic [LVL_WIDTH-1:0]  acc_level
);

  localparam logic [LVL_WIDTH-1:0] LvlFull = LVL_WIDTH'(PACK_RATIO);

  logic [OUT_WIDTH-1:0]  acc_d, acc_q;
  logic [LVL_WIDTH-1:0]  lvl_d, lvl_q;
  logic                  pend_d, pend_q;
  logic                  done_d, done_q;
  logic                  tvalid_q;
  logic [OUT_WIDTH-1:0]  tdata_q;
  logic [PACK_RATIO-1:0] tkeep_q;
  logic                  tlast_q;

  logic                  out_free;
  logic                  xfer;
  logic [PACK_RATIO-1:0] fill_mask;

  assign m.tvalid   = tvalid_q;
  assign m.tdata    = tdata_q;
  assign m.tkeep    = tkeep_q;
  assign m.tlast    = tlast_q;
  assign acc_level  = lvl_q;
  assign flush_done = done_q;

  always_comb begin
    out_free = !tvalid_q || m.tready;
    // A full accumulator always moves; a partial one only when a flush is pending.
    xfer = out_free && ((lvl_q == LvlFull) || (pend_q && (lvl_q != '0)));
    // Popping while full is allowed only when the same edge empties the accumulator.
    fifo_rd_en = !fifo_empty && !flush && !pend_q && ((lvl_q < LvlFull) || xfer);
  end

  always_comb begin
    fill_mask = '0;
    for (int i = 0; i < PACK_RATIO; i++) begin
      fill_mask[i] = LVL_WIDTH'(i) < lvl_q;
    end
  end

  // Accumulator next state: clear on xfer first, so a same-cycle pop lands in slot 0.
  always_comb begin
    acc_d = acc_q;
    lvl_d = lvl_q;
    if (xfer) begin
      acc_d = '0;
      lvl_d = '0;
    end
    if (fifo_rd_en) begin
      for (int i = 0; i < PACK_RATIO; i++) begin
        if (LVL_WIDTH'(i) == lvl_d) begin
          acc_d[i*DATA_WIDTH +: DATA_WIDTH] = fifo_rd_data;
        end
      end
      lvl_d = lvl_d + LVL_WIDTH'(1);
    end
  end

  // Flush completes on the edge that emits the partial beat, or immediately if empty.
  always_comb begin
    done_d = pend_q && ((lvl_q == '0) || xfer);
    pend_d = pend_q ? !done_d : flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      lvl_q    <= '0;
      pend_q   <= 1'b0;
      done_q   <= 1'b0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tlast_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      lvl_q  <= lvl_d;
      pend_q <= pend_d;
      done_q <= done_d;
      if (xfer) begin
        tdata_q  <= acc_q;
        tkeep_q  <= fill_mask;
        tlast_q  <= pend_q;
        tvalid_q <= 1'b1;
      end else if (out_free) begin
        tvalid_q <= 1'b0;
      end
    end
  end

endmodule
